data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/dcache_pkg.sv | 17 +
 rtl/dcache_array.sv | 60 ++++++
 rtl/data_cache.sv | 165 ++++++++++++++++
 tb/tb_data_cache.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int DEF_LINES      = 64;
    localparam int DEF_LINE_WORDS = 4;

    localparam int DEF_OFF_W = $clog2(DEF_LINE_WORDS);
    localparam int DEF_IDX_W = $clog2(DEF_LINES);
    localparam int DEF_TAG_W = 32 - DEF_IDX_W - DEF_OFF_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read at one index, one synchronous word write per cycle.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int IDX_W      = $clog2(LINES),
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = 32 - IDX_W - OFF_W - 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [IDX_W-1:0] index,
    input  logic [OFF_W-1:0] offset,
    output logic             line_valid,
    output logic [TAG_W-1:0] line_tag,
    output logic [31:0]      word,
    input  logic             word_we,
    input  logic [OFF_W-1:0] word_offset,
    input  logic [31:0]      word_data,
    input  logic             line_we,
    input  logic [TAG_W-1:0] line_tag_in
);

    logic [LINES-1:0] valid_reg;
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [31:0]      lane_word [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= '0;
        end else if (line_we) begin
            valid_reg[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[index] <= line_tag_in;
        end
    end

    // One storage column per word position keeps each RAM a single write port.
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_lane
        logic [31:0] lane_mem [LINES];

        always_ff @(posedge clk) begin
            if (word_we && word_offset == OFF_W'(gi)) begin
                lane_mem[index] <= word_data;
            end
        end

        assign lane_word[gi] = lane_mem[index];
    end

    assign line_valid = valid_reg[index];
    assign line_tag   = tag_mem[index];
    assign word       = lane_word[offset];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill FSM.
// Defining DCACHE_PERF_EN adds HitCount/MissCount outputs.
module data_cache
    import dcache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Den,
    input  logic        DWen,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWriteData,
    output logic [31:0] DReadData,
    output logic        DStall,
    output logic        MemReq,
    output logic        MemWen,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemReady,
    input  logic [31:0] MemRData
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

    state_t           state_reg, state_next;
    logic [OFF_W-1:0] cnt_reg, cnt_next;

    logic [OFF_W-1:0] addr_off;
    logic [IDX_W-1:0] addr_idx;
    logic [TAG_W-1:0] addr_tag;
    logic             arr_valid;
    logic [TAG_W-1:0] arr_tag;
    logic [31:0]      arr_word;
    logic             hit;
    logic             word_we, line_we;
    logic [OFF_W-1:0] word_off;
    logic [31:0]      word_data;
    logic             unused_addr_bits;

    assign addr_off         = DAddr[OFF_W+1:2];
    assign addr_idx         = DAddr[OFF_W+2 +: IDX_W];
    assign addr_tag         = DAddr[31 -: TAG_W];
    assign hit              = arr_valid && (arr_tag == addr_tag);
    assign unused_addr_bits = ^DAddr[1:0];

    // Writes are squashed while reset is high so an interrupted beat leaves no trace.
    dcache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk         (clk),
        .srst        (reset),
        .index       (addr_idx),
        .offset      (addr_off),
        .line_valid  (arr_valid),
        .line_tag    (arr_tag),
        .word        (arr_word),
        .word_we     (word_we && !reset),
        .word_offset (word_off),
        .word_data   (word_data),
        .line_we     (line_we && !reset),
        .line_tag_in (addr_tag)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        DStall     = 1'b0;
        DReadData  = '0;
        MemReq     = 1'b0;
        MemWen     = 1'b0;
        MemAddr    = '0;
        MemWData   = '0;
        word_we    = 1'b0;
        line_we    = 1'b0;
        word_off   = addr_off;
        word_data  = DWriteData;
        case (state_reg)
            IDLE: begin
                if (Den) begin
                    if (DWen) begin
                        DStall     = 1'b1;
                        state_next = WRITE;
                    end else if (hit) begin
                        DReadData = arr_word;
                    end else begin
                        DStall     = 1'b1;
                        cnt_next   = '0;
                        state_next = REFILL;
                    end
                end
            end
            REFILL: begin
                MemReq    = 1'b1;
                MemAddr   = {addr_tag, addr_idx, cnt_reg, 2'b00};
                DStall    = 1'b1;
                word_off  = cnt_reg;
                word_data = MemRData;
                if (MemReady) begin
                    word_we  = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == OFF_W'(LINE_WORDS - 1)) begin
                        line_we    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                MemReq   = 1'b1;
                MemWen   = 1'b1;
                MemAddr  = {DAddr[31:2], 2'b00};
                MemWData = DWriteData;
                DStall   = !MemReady;
                if (MemReady) begin
                    word_we    = hit;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (state_reg == IDLE && Den && !DWen) begin
            if (hit) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end else begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign HitCount  = hit_cnt_reg;
    assign MissCount = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: reference cache/memory model, random memory latency.
module tb_data_cache;

    localparam int LINES = 64;
    localparam int LW    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        Den, DWen;
    logic [31:0] DAddr, DWriteData, DReadData;
    logic        DStall, MemReq, MemWen;
    logic [31:0] MemAddr, MemWData;
    logic        MemReady;
    logic [31:0] MemRData;
`ifdef DCACHE_PERF_EN
    logic [31:0] HitCount, MissCount;
`endif

    data_cache #(.LINES(LINES), .LINE_WORDS(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .Den        (Den),
        .DWen       (DWen),
        .DAddr      (DAddr),
        .DWriteData (DWriteData),
        .DReadData  (DReadData),
        .DStall     (DStall),
        .MemReq     (MemReq),
        .MemWen     (MemWen),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemReady   (MemReady),
        .MemRData   (MemRData)
`ifdef DCACHE_PERF_EN
        ,
        .HitCount   (HitCount),
        .MissCount  (MissCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          beats;
        int          lat;
        int          issue;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        bit          wen;
        logic [31:0] wdata;
    } beat_t;

    txn_t  txn_q[$];
    beat_t beat_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit sb_off = 1'b1;
    bit fast = 1'b1;
    int fixed_delay = 0;

    // Reference state: which line each index holds, and the backing memory.
    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];
    logic [31:0] mem_wr [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_wr.exists(a)) return mem_wr[a];
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder
    bit busy = 1'b0;
    int wcnt = 0;
    always begin
        @(posedge clk);
        #2;
        if (fast) begin
            MemReady = 1'b1;
            MemRData = MemReq ? mem_rd(MemAddr) : $urandom;
            if (MemReq && MemWen && !reset) mem_wr[MemAddr] = MemWData;
        end else if (MemReq) begin
            if (!busy) begin
                busy = 1'b1;
                wcnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
            end
            if (wcnt == 0) begin
                MemReady = 1'b1;
                MemRData = mem_rd(MemAddr);
                if (MemWen && !reset) mem_wr[MemAddr] = MemWData;
                busy = 1'b0;
            end else begin
                MemReady = 1'b0;
                MemRData = $urandom;
                wcnt--;
            end
        end else begin
            busy     = 1'b0;
            MemReady = 1'($urandom_range(0, 1));
            MemRData = $urandom;
        end
    end

    // Monitor: bus stability, beat scoreboard, completion scoreboard.
    logic        p_req = 1'b0, p_rdy = 1'b0, p_wen = 1'b0, p_rst = 1'b1;
    logic [31:0] p_addr = '0, p_wdata = '0;
    int          beats_seen = 0;
    always begin
        @(negedge clk);
        if (p_req && !p_rdy && !p_rst && !reset) begin
            check("hold_req", {31'd0, MemReq}, 32'd1);
            check("hold_addr", MemAddr, p_addr);
            check("hold_wen", {31'd0, MemWen}, {31'd0, p_wen});
            if (p_wen) check("hold_wdata", MemWData, p_wdata);
        end
        p_req = MemReq; p_rdy = MemReady; p_wen = MemWen; p_rst = reset;
        p_addr = MemAddr; p_wdata = MemWData;
        if (!sb_off && !reset && MemReq && MemReady) begin
            beats_seen++;
            if (beat_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat_unexpected: got addr %h expected no beat", MemAddr);
            end else begin
                beat_t b;
                b = beat_q.pop_front();
                check("beat_addr", MemAddr, b.addr);
                check("beat_wen", {31'd0, MemWen}, {31'd0, b.wen});
                if (b.wen) check("beat_wdata", MemWData, b.wdata);
            end
        end
        if (!sb_off && !reset && Den && !DStall) begin
            if (txn_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL txn_unexpected: got completion at %h expected none", DAddr);
            end else begin
                txn_t t;
                t = txn_q.pop_front();
                if (!t.is_write) check("load_data", DReadData, t.rdata);
                check("txn_beats", beats_seen, t.beats);
                if (t.lat >= 0) check("txn_latency", cyc - t.issue, t.lat);
                $display("txn %s addr=%h data=%h beats=%0d lat=%0d", t.is_write ? "ST" : "LD",
                         t.addr, t.is_write ? DWriteData : DReadData, beats_seen, cyc - t.issue);
            end
            beats_seen = 0;
        end
    end

    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        txn_t        t;
        beat_t       b;
        logic [31:0] wa, idx, tg;
        bit          hit;
        bit          done;
        wa  = addr & ~32'd3;
        idx = (wa / (LW * 4)) % LINES;
        tg  = wa / (LW * 4 * LINES);
        hit = mvalid[idx] && (mtag[idx] == tg);
        t.is_write = we;
        t.addr     = addr;
        t.rdata    = mem_rd(wa);
        t.issue    = cyc;
        if (we) begin
            b.addr = wa; b.wen = 1'b1; b.wdata = wd;
            beat_q.push_back(b);
            t.beats = 1;
            t.lat   = (fixed_delay >= 0) ? 1 + fixed_delay : -1;
        end else if (hit) begin
            t.beats = 0;
            t.lat   = 0;
        end else begin
            for (int k = 0; k < LW; k++) begin
                b.addr = wa - (wa % (LW * 4)) + 32'(4 * k); b.wen = 1'b0; b.wdata = '0;
                beat_q.push_back(b);
            end
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            t.beats = LW;
            t.lat   = (fixed_delay >= 0) ? LW * (fixed_delay + 1) + 1 : -1;
        end
        txn_q.push_back(t);
        Den = 1'b1; DWen = we; DAddr = addr; DWriteData = wd;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            if (!DStall) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: got no completion for %h expected completion within 500 cycles", addr);
            txn_q.delete(); beat_q.delete();
        end
        @(posedge clk); #1;
        Den = 1'b0; DWen = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stall"}, {31'd0, DStall}, 32'd0);
        check({tag, "_rdata"}, DReadData, 32'd0);
        check({tag, "_memreq"}, {31'd0, MemReq}, 32'd0);
        check({tag, "_memwen"}, {31'd0, MemWen}, 32'd0);
        check({tag, "_memaddr"}, MemAddr, 32'd0);
        check({tag, "_memwdata"}, MemWData, 32'd0);
    endtask

    initial begin
        reset = 1'b1; Den = 1'b0; DWen = 1'b0; DAddr = '0; DWriteData = '0;
        MemReady = 1'b0; MemRData = '0;
        for (int i = 0; i < LINES; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        sb_off = 1'b0;

        // Miss + refill, then hit in the same line.
        fast = 1'b1; fixed_delay = 0;
        do_access(1'b0, 32'h0000_0040, '0);
        do_access(1'b0, 32'h0000_0048, '0);
`ifdef DCACHE_PERF_EN
        check("miss_count", MissCount, 32'd1);
        check("hit_count", HitCount, 32'd2);
`endif
        // Write-through hit with a slow memory, then read back.
        fast = 1'b0; fixed_delay = 3;
        do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        fast = 1'b1; fixed_delay = 0;
        do_access(1'b0, 32'h0000_0044, '0);
        // Write miss: no allocation, so the following read refills.
        do_access(1'b1, 32'h0000_1000, 32'h1234_5678);
        do_access(1'b0, 32'h0000_1000, '0);

        // Reset on the second refill beat abandons the line.
        sb_off = 1'b1;
        Den = 1'b1; DWen = 1'b0; DAddr = 32'h0000_2000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; Den = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        txn_q.delete(); beat_q.delete(); beats_seen = 0;
        @(posedge clk); #1;
        sb_off = 1'b0;
        do_access(1'b0, 32'h0000_2000, '0);

        // Randomized traffic with random memory latency and idle gaps.
        fast = 1'b0; fixed_delay = -1;
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4)
              | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) begin
                DAddr = $urandom;
                @(negedge clk);
                check("gap_stall", {31'd0, DStall}, 32'd0);
                check("gap_rdata", DReadData, 32'd0);
                check("gap_memreq", {31'd0, MemReq}, 32'd0);
                @(posedge clk); #1;
            end
            do_access($urandom_range(0, 9) < 4, a, $urandom);
        end

        repeat (2) @(posedge clk);
        if (txn_q.size() != 0 || beat_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d txns %0d beats pending expected 0", txn_q.size(), beat_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
